bf_loop_unit: RTL
=================

Name: bf_loop_unit

Overview:
- Control-flow companion to the instruction-pointer controller in the bfcpu core.
- Consumes the current ip and the decoded opcode at that ip, and drives update_ip / jmp / jmp_target back into the ip controller.
- Resolves Brainfuck loops: a return-address stack handles ']' back-jumps, and a nesting-depth skip scan handles '[' with a zero cell.

Parameters:
- I_ADDR_WIDTH, 16, width of ip and jmp_target.
- STACK_DEPTH, 16, number of open-loop entries held; power of two, at least 2.
- SKIP_CNT_WIDTH, 8, width of the nesting counter used in SKIP.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ip  input  I_ADDR_WIDTH  current instruction address from the ip controller.
- insn_valid  input  1  insn is valid for the current ip this cycle.
- insn  input  8  ASCII opcode at ip.
- cell_zero  input  1  current data cell == 0; sampled only in RUN.
- update_ip  output  1  ip controller advances or jumps at the next edge.
- jmp  output  1  select jmp_target instead of ip+1.
- jmp_target  output  I_ADDR_WIDTH  jump destination.
- busy  output  1  high in SKIP; core suppresses data-side execution.
- loop_depth  output  clog2(STACK_DEPTH)+1  current stack occupancy (sp).
- err_overflow  output  1  sticky: stack push when full, or skip counter saturated.
- err_underflow  output  1  sticky: ']' executed with an empty stack.

Behaviour:
- Reset, asynchronous, while rst is high:
  - state=RUN, sp=0, skip_cnt=0, both err flags 0.
  - Outputs: update_ip=0, jmp=0, busy=0, loop_depth=0, jmp_target=0.
- Timing:
  - update_ip, jmp and jmp_target are combinational (Mealy) from state, insn_valid, insn and cell_zero.
  - The ip controller registers them, so the new ip is visible one edge after the decision.
  - State, stack and counters update on that same edge.
- If insn_valid=0: update_ip=0, jmp=0, no state change, in every state.
- jmp_target = stack[sp-1] + 1, modulo 2^I_ADDR_WIDTH. It is 0 when sp==0. Only meaningful when jmp=1.
- State RUN (busy=0), with insn_valid=1:
  - '[' (0x5B), cell_zero=0:
    - sp<STACK_DEPTH: push ip, sp+1, update_ip=1, jmp=0.
    - sp==STACK_DEPTH: go to ERR, set err_overflow, update_ip=0.
  - '[' (0x5B), cell_zero=1: update_ip=1, jmp=0, skip_cnt=1, go to SKIP. No push.
  - ']' (0x5D), sp==0: go to ERR, set err_underflow, update_ip=0.
  - ']' (0x5D), cell_zero=0: update_ip=1, jmp=1, target as above. No pop; the loop stays open.
  - ']' (0x5D), cell_zero=1: pop (sp-1), update_ip=1, jmp=0.
  - Any other byte: update_ip=1, jmp=0.
- State SKIP (busy=1), with insn_valid=1:
  - update_ip=1 and jmp=0 always; cell_zero is ignored.
  - '[': skip_cnt+1. If skip_cnt is already all-ones, go to ERR and set err_overflow.
  - ']': skip_cnt-1. When the result is 0, go to RUN on this edge. The matching ']' is consumed, not executed.
  - Any other byte: no change.
  - The stack is untouched throughout SKIP.
- State ERR:
  - update_ip=0, jmp=0, busy=0; the core halts.
  - Error flags and sp are held; only rst exits.
- Simultaneous events:
  - A push and a pop can never occur in the same cycle (one insn per cycle).
  - Reset mid-SKIP or mid-loop clears everything immediately.
  - ip wrap-around is not checked.
- Encoding: the state register holds 3 states; the unreachable encoding goes to ERR with no flag set.

Test Plan:
- Program "+[-]" at 0..3, cell nonzero for 2 passes:
  - The ']' at ip=3 gives jmp=1, jmp_target=2 twice.
  - Then with cell_zero=1: pop, loop_depth goes 1 to 0, ip reaches 4.
- "[[+]]+" from ip=0 with cell_zero=1:
  - busy goes high for 4 cycles and skip_cnt steps 1,2,1,0.
  - Back in RUN at ip=5 with sp=0, no jmp asserted.
- 17 consecutive '[' with cell nonzero:
  - loop_depth reaches 16.
  - The 17th raises err_overflow; update_ip=0 thereafter.
- Single ']' at reset:
  - err_underflow=1, update_ip=0.
  - Flags hold through 10 further valid insns.
- Assert rst asynchronously mid-SKIP (skip_cnt=2):
  - Outputs go to reset values without waiting for a clock edge.
  - After release, '+' gives update_ip=1, jmp=0.
- insn_valid=0 for 5 cycles inside a loop:
  - update_ip=0, loop_depth unchanged, no state change.

Source files
------------

// File: rtl/bf_loop_unit.sv
// bf_loop_unit: Brainfuck loop resolver driving the ip controller.
// A return-address stack serves ']' back-jumps; a nesting counter skips '[' bodies with a zero cell.
module bf_loop_unit #(
    parameter int I_ADDR_WIDTH   = 16,
    parameter int STACK_DEPTH    = 16,
    parameter int SKIP_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [I_ADDR_WIDTH-1:0]       ip,
    input  logic                          insn_valid,
    input  logic [7:0]                    insn,
    input  logic                          cell_zero,
    output logic                          update_ip,
    output logic                          jmp,
    output logic [I_ADDR_WIDTH-1:0]       jmp_target,
    output logic                          busy,
    output logic [$clog2(STACK_DEPTH):0]  loop_depth,
    output logic                          err_overflow,
    output logic                          err_underflow
);
    localparam int AW = $clog2(STACK_DEPTH);
    typedef enum logic [1:0] {RUN = 2'd0, SKIP = 2'd1, ERR = 2'd2} state_t;
    state_t                    state;
    logic [I_ADDR_WIDTH-1:0]   stack [STACK_DEPTH];
    logic [AW:0]               sp;
    logic [SKIP_CNT_WIDTH-1:0] skip_cnt;
    logic [AW-1:0]             top;
    logic                      is_open, is_close, run, skip, full, empty, push;
    assign is_open  = insn == 8'h5B;
    assign is_close = insn == 8'h5D;
    assign run      = state == RUN;
    assign skip     = state == SKIP;
    assign full     = sp[AW];
    assign empty    = sp == '0;
    assign top      = sp[AW-1:0] - 1'b1;
    // rst gating keeps the Mealy outputs quiet while reset is held with a valid insn
    always_comb begin
        update_ip = !rst && insn_valid && (skip || run && !(is_open && !cell_zero && full) && !(is_close && empty));
        jmp       = !rst && insn_valid && run && is_close && !empty && !cell_zero;
        push      = !rst && insn_valid && run && is_open && !cell_zero && !full;
    end
    assign jmp_target = empty ? '0 : stack[top] + 1'b1;
    assign busy       = skip;
    assign loop_depth = sp;
    always_ff @(posedge clk)
        if (push) stack[sp[AW-1:0]] <= ip;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= RUN;
            sp            <= '0;
            skip_cnt      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            case (state)
                RUN: if (insn_valid) begin
                    if (is_open) begin
                        if (cell_zero) begin
                            skip_cnt <= SKIP_CNT_WIDTH'(1);
                            state    <= SKIP;
                        end else if (full) begin
                            state        <= ERR;
                            err_overflow <= 1'b1;
                        end else sp <= sp + 1'b1;
                    end else if (is_close) begin
                        if (empty) begin
                            state         <= ERR;
                            err_underflow <= 1'b1;
                        end else if (cell_zero) sp <= sp - 1'b1;
                    end
                end
                SKIP: if (insn_valid) begin
                    if (is_open) begin
                        if (&skip_cnt) begin
                            state        <= ERR;
                            err_overflow <= 1'b1;
                        end else skip_cnt <= skip_cnt + 1'b1;
                    end else if (is_close) begin
                        skip_cnt <= skip_cnt - 1'b1;
                        if (skip_cnt == SKIP_CNT_WIDTH'(1)) state <= RUN;
                    end
                end
                ERR: ;
                default: state <= ERR;
            endcase
        end
endmodule
